// File: rtl/mem_responder.sv
// Word-addressed memory that completes each read or write a fixed number of
// cycles after it is accepted.
//   state | meaning
//   IDLE  | waiting for a request; accepts mem_read/mem_write on the edge
//   BUSY  | latency counter running down from LATENCY-2 to 0
//   RESP  | mem_resp high; write committed / read data loaded on entry
module mem_responder #(
  parameter int LATENCY     = 3,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept, enter_resp;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            wr_q;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic [3:0]      c_be;
  logic            c_wr;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            addr_unused;

  assign addr_unused = ^{mem_address[31:AW+2], mem_address[1:0]};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the commit happens on the accepting edge itself, so the
  // live inputs must be used instead of the (not yet loaded) latches.
  always_comb begin
    if (state == IDLE) begin
      c_idx   = mem_address[AW+1:2];
      c_wdata = mem_wdata;
      c_be    = mem_byte_enable;
      c_wr    = mem_write;
    end else begin
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_be    = be_q;
      c_wr    = wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_rdata <= 32'h0;
      proto_err <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      wr_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q   <= mem_address[AW+1:2];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        wr_q    <= mem_write;
        if (mem_read && mem_write) proto_err <= 1'b1;
      end
      if (enter_resp && !c_wr) mem_rdata <= mem[c_idx];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && c_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign mem_resp = (state == RESP);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: LATENCY, default 3, cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 Parameter: DEPTH_WORDS, default 256, number of 32-bit words stored; power of two, at least 4.
REQ-003 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port: rst, input, 1, synchronous active-high reset.
REQ-005 Port: mem_read, input, 1, read request; held high by the initiator until mem_resp.
REQ-006 Port: mem_write, input, 1, write request; held high by the initiator until mem_resp.
REQ-007 Port: mem_address, input, 32, byte address; bits [1:0] are ignored.
REQ-008 Port: mem_wdata, input, 32, write data.
REQ-009 Port: mem_byte_enable, input, 4, write byte mask; bit i enables byte lane [8i+7:8i].
REQ-010 Port: mem_rdata, output, 32, read data.
REQ-011 Port: mem_resp, output, 1, one-cycle completion strobe.
REQ-012 Port: proto_err, output, 1, sticky flag recording a simultaneous read and write request.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-014 Word index = mem_address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-015 Acceptance: in IDLE with mem_read or mem_write high, the block SHALL latch the address, wdata, byte_enable and operation type at the rising edge.
- LATENCY=1: next state RESP.
- Otherwise: next state BUSY, with the counter loaded to LATENCY-2.
REQ-016 BUSY SHALL decrement the counter each cycle and move to RESP when the counter is 0.
REQ-017 A request accepted during cycle n SHALL produce mem_resp=1 during cycle n+LATENCY only, for exactly one cycle.
REQ-018 RESP SHALL always go to IDLE on the next edge.
- A request still high in that IDLE cycle SHALL be accepted as a new request.
- This means back-to-back requests are allowed, with a minimum period of LATENCY+1 cycles.
REQ-019 Input changes during BUSY or RESP SHALL be ignored; only the latched values are used.
REQ-020 Write commit: on the edge entering RESP, each byte lane whose latched mask bit is 1 SHALL be updated; other lanes SHALL be unchanged.
REQ-021 A write with mask 4'b0000 SHALL complete normally and modify nothing.
REQ-022 Read data: on the edge entering RESP, mem_rdata SHALL be loaded with the full word at the latched index; mem_byte_enable has no effect on reads.
REQ-023 mem_rdata SHALL hold its value until the next read completes; writes SHALL NOT change mem_rdata.
REQ-024 Simultaneous mem_read and mem_write at acceptance:
- The request SHALL be treated as a write.
- proto_err SHALL be set to 1 and remain set until reset.
REQ-025 mem_resp SHALL be a registered output: high if and only if the state is RESP.

Reset
REQ-026 With rst high at an edge, the block SHALL enter IDLE and clear the counter to 0, mem_resp to 0, mem_rdata to 32'h0 and proto_err to 0.
REQ-027 Storage contents SHALL NOT be cleared by reset.
REQ-028 Reset during BUSY SHALL abort the transaction.
- No write commit and no mem_resp.
- A request held high after rst falls SHALL be accepted as new in the first IDLE cycle.
REQ-029 Reset takes priority over every other transition, including the edge that would enter RESP.

Verification
REQ-030 Write then read, LATENCY=3:
- Stimulus: write addr 0x10, data 0xDEADBEEF, be 4'b1111 in cycle n; then read addr 0x10.
- Required: mem_resp high in cycle n+3 only; the read returns 0xDEADBEEF.
REQ-031 Partial write:
- Stimulus: after REQ-030, write addr 0x10, data 0x000000AA, be 4'b0001; then read addr 0x10.
- Required: mem_rdata = 0xDEADBEAA.
REQ-032 Address wrap, DEPTH_WORDS=256:
- Stimulus: write 0x12345678 to addr 0x400, read addr 0x000; also read with mem_address[1:0]=2'b11.
- Required: both reads return 0x12345678.
REQ-033 Held request: mem_read held high continuously produces mem_resp every LATENCY+1 cycles.
REQ-034 Reset mid-operation:
- Stimulus: rst pulsed in the second BUSY cycle of a write of 0x55 to addr 0x20.
- Required: no mem_resp; a subsequent read of addr 0x20 returns the prior contents.
REQ-035 Simultaneous request:
- Stimulus: read and write both high, wdata 0x0F0F0F0F.
- Required: proto_err=1; the word is written; proto_err stays 1 until rst.
